// File: rtl/apb_master.sv
// APB4 requester bridging a valid/ready request/response pair to a single APB transfer.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter logic [2:0]  PPROT          = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [2:0]  out_pprot,
  output logic [31:0] out_paddr,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic        out_pslverr,
  input  logic [31:0] out_prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        timeout;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        write_q, err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          wait_cnt <= '0;
    else if (state == SETUP)               wait_cnt <= '0;
    else if (state == ACCESS && !out_pready) wait_cnt <= wait_cnt + 16'd1;
  end

  // Fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle; a same-cycle pready still wins.
  assign timeout = (state == ACCESS) && !out_pready &&
                   (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset_n;
        if (req_valid) state_next = SETUP;
      end
      SETUP: begin
        out_psel   = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready || timeout) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data/strobes are zeroed at capture so the APB bus never carries stale write data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_write ? req_wdata : '0;
        wstrb_q <= req_write ? req_wstrb : '0;
      end
      if (state == ACCESS) begin
        if (out_pready) begin
          err_q   <= out_pslverr;
          rdata_q <= (write_q || out_pslverr) ? '0 : out_prdata;
        end else if (timeout) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign out_pprot  = PPROT;
  assign out_paddr  = addr_q;
  assign out_pwrite = write_q;
  assign out_pwdata = wdata_q;
  assign out_pstrb  = wstrb_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of single transfers plus hold,
// back-to-back, reset-abort and watchdog sequences.
module tb_apb_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [31:0] out_paddr, out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0, out_pslverr = 1'b0;
  logic [31:0] out_prdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  apb_master #(.PPROT(3'b000), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_pprot(out_pprot), .out_paddr(out_paddr), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_pslverr(out_pslverr),
    .out_prdata(out_prdata)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_pwdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Called at the SETUP-cycle negedge; plays the slave until psel drops or the bound expires.
  task automatic access_phase(input logic [31:0] e_addr, input logic e_wr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input int ws, input logic [31:0] rd,
                              input logic err, output int nacc, output int nbad);
    nacc = 0; nbad = 0;
    out_pready = 1'b1; out_prdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!(out_psel && out_penable)) break;
      nacc++;
      if (out_paddr !== e_addr || out_pwrite !== e_wr || out_pstrb !== e_strb ||
          out_pwdata !== e_wdata) nbad++;
      out_pready = (k == ws); out_prdata = rd; out_pslverr = err;
    end
    out_pready = 1'b0; out_pslverr = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int nacc, nbad;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    issue(v.wr, v.addr, v.wdata, v.strb);
    check("setup_sel_en", {30'd0, out_psel, out_penable}, 32'd2);
    check("setup_paddr", out_paddr, v.addr);
    check("setup_pwrite", 32'(out_pwrite), 32'(v.wr));
    check("setup_pstrb", 32'(out_pstrb), 32'(v.exp_pstrb));
    check("setup_pwdata", out_pwdata, v.exp_pwdata);
    check("setup_req_ready", 32'(req_ready), 32'd0);
    access_phase(v.addr, v.wr, v.exp_pstrb, v.exp_pwdata, v.ws, v.prdata, v.slverr, nacc, nbad);
    check("access_cycles", 32'(nacc), 32'(v.ws + 1));
    check("access_stable", 32'(nbad), 32'd0);
    check("latency", 32'(nacc + 2), 32'(v.ws + 3));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("resp_psel", 32'(out_psel), 32'd0);
    check("resp_paddr_hold", out_paddr, v.addr);
    drain();
  endtask

  initial begin
    int nacc, nbad;
    vecs[0] = '{1'b1, 32'h1000_0003, 32'h0000_00A5, 4'b1000, 0, 32'h1111_1111, 1'b0,
                32'h0, 1'b0, 4'b1000, 32'h0000_00A5};
    vecs[1] = '{1'b0, 32'h1000_0005, 32'hFFFF_FFFF, 4'b1111, 2, 32'h5A5A_5A5A, 1'b0,
                32'h5A5A_5A5A, 1'b0, 4'b0000, 32'h0};
    vecs[2] = '{1'b0, 32'h2000_0010, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF, 1'b1,
                32'h0, 1'b1, 4'b0000, 32'h0};
    vecs[3] = '{1'b1, 32'h3000_0000, 32'hCAFE_0001, 4'b0011, 1, 32'h0, 1'b1,
                32'h0, 1'b1, 4'b0011, 32'hCAFE_0001};
    vecs[4] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'b1111, 0, 32'h7777_7777, 1'b0,
                32'h0, 1'b0, 4'b1111, 32'h1234_5678};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0000, 0, 32'h0000_0001, 1'b0,
                32'h0000_0001, 1'b0, 4'b0000, 32'h0};

    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_psel_en", {30'd0, out_psel, out_penable}, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_paddr", out_paddr, 32'd0);
    check("rst_pwdata_pstrb", {out_pwdata[27:0], out_pstrb}, 32'd0);
    check("pprot", 32'(out_pprot), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Response held with rsp_ready low, then a back-to-back request
    issue(1'b0, 32'h4000_0000, 32'h0, 4'b0000);
    access_phase(32'h4000_0000, 1'b0, 4'b0000, 32'h0, 0, 32'h0BAD_F00D, 1'b0, nacc, nbad);
    for (int c = 0; c < 5; c++) begin
      check("hold_state", {rsp_valid, req_ready, rsp_err, out_psel}, 4'b1000);
      check("hold_rdata", rsp_rdata, 32'h0BAD_F00D);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h5000_0008;
    req_wdata = 32'hA5A5_0000; req_wstrb = 4'b1100;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("b2b_idle", {rsp_valid, req_ready, out_psel}, 3'b010);
    @(negedge clock);
    req_valid = 1'b0;
    check("b2b_setup", {out_psel, out_penable}, 2'b10);
    check("b2b_paddr", out_paddr, 32'h5000_0008);
    access_phase(32'h5000_0008, 1'b1, 4'b1100, 32'hA5A5_0000, 0, 32'h0, 1'b0, nacc, nbad);
    check("b2b_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("b2b_rdata", rsp_rdata, 32'h0);
    drain();

    // Reset pulse during ACCESS aborts without a response
    issue(1'b0, 32'h6000_0000, 32'h0, 4'b0000);
    @(negedge clock);
    check("pre_rst_access", {out_psel, out_penable}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_psel", {out_psel, out_penable}, 2'b00);
    check("rst_mid_outs", {rsp_valid, req_ready, 30'd0, out_paddr[1:0]}, 32'd0);
    check("rst_mid_paddr", out_paddr, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst", {req_ready, rsp_valid, out_psel}, 3'b100);
    run_vec(vecs[1]);

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave is cut off after 4 ACCESS cycles
    issue(1'b0, 32'h7000_0000, 32'h0, 4'b0000);
    access_phase(32'h7000_0000, 1'b0, 4'b0000, 32'h0, 1000, 32'h1234_0000, 1'b0, nacc, nbad);
    check("to_cycles", 32'(nacc), 32'd4);
    check("to_rsp", {rsp_valid, rsp_err, out_psel}, 3'b110);
    check("to_rdata", rsp_rdata, 32'h0);
    drain();
    // pready on the timeout cycle completes normally
    issue(1'b0, 32'h7000_0004, 32'h0, 4'b0000);
    access_phase(32'h7000_0004, 1'b0, 4'b0000, 32'h0, 3, 32'h00C0_FFEE, 1'b0, nacc, nbad);
    check("to_race_cycles", 32'(nacc), 32'd4);
    check("to_race_err", 32'(rsp_err), 32'd0);
    check("to_race_rdata", rsp_rdata, 32'h00C0_FFEE);
    drain();
`else
    // Without the watchdog a stuck slave keeps the transfer open
    issue(1'b0, 32'h7000_0000, 32'h0, 4'b0000);
    access_phase(32'h7000_0000, 1'b0, 4'b0000, 32'h0, 1000, 32'h0, 1'b0, nacc, nbad);
    check("stuck_cycles", 32'(nacc), 32'd200);
    check("stuck_sel_en", {out_psel, out_penable, rsp_valid}, 3'b110);
    check("stuck_stable", 32'(nbad), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("stuck_recover", {req_ready, out_psel}, 2'b10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
